dff: RTL and testbench

DFF -- requirements
Module: dff

---
 rtl/dff_pkg.sv | 11 +
 rtl/dff_stage.sv | 26 ++
 rtl/dff.sv | 78 +++++++
 tb/tb_dff.sv | 116 +++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// Shared constants for the dff pipeline register.
package dff_pkg;

  localparam int DFF_MIN_DEPTH = 1;
  localparam int DFF_MAX_DEPTH = 16;

  function automatic bit dff_depth_ok(input int depth);
    return (depth >= DFF_MIN_DEPTH) && (depth <= DFF_MAX_DEPTH);
  endfunction

endpackage : dff_pkg

// File: rtl/dff_stage.sv
// Single WIDTH-bit register with synchronous active-low reset.
module dff_stage #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = d_i;
    if (!rst_n) q_d = RST_VAL;
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule : dff_stage

// File: rtl/dff.sv
// DEPTH-stage register pipeline from d to q with synchronous active-low reset.
module dff
  import dff_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               DEPTH   = 1
) (
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             rst
);

  if (!dff_depth_ok(DEPTH)) begin : g_bad_depth
    $fatal(1, "dff: DEPTH=%0d outside legal range 1..16", DEPTH);
  end
  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "dff: WIDTH=%0d must be at least 1", WIDTH);
  end

  logic [WIDTH-1:0] stage_q [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] stage_d;
    if (i == 0) begin : g_first
      assign stage_d = d;
    end else begin : g_next
      assign stage_d = stage_q[i-1];
    end

    dff_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst),
      .d_i   (stage_d),
      .q_o   (stage_q[i])
    );
  end

  assign q = stage_q[DEPTH-1];

`ifndef SYNTHESIS
  // Reference history of d: q must match it once DEPTH clean edges have passed.
  logic             rst_prev_q;
  logic             rst_seen_q;
  int               run_q;
  logic [WIDTH-1:0] hist_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst_prev_q) begin
      assert (q == RST_VAL)
        else $error("dff: q=%h after reset edge, RST_VAL=%h", q, RST_VAL);
    end
    if (run_q >= DEPTH) begin
      assert (q == hist_q[DEPTH-1])
        else $error("dff: q=%h does not match d delayed by %0d edges (%h)",
                    q, DEPTH, hist_q[DEPTH-1]);
    end

    rst_prev_q <= !rst;
    rst_seen_q <= rst_seen_q | !rst;
    if (!rst) begin
      run_q <= 0;
    end else if (rst_seen_q && run_q < DEPTH) begin
      run_q <= run_q + 1;
    end

    hist_q[0] <= d;
    for (int k = 1; k < DEPTH; k++) begin
      hist_q[k] <= hist_q[k-1];
    end
  end
`endif

endmodule : dff

// File: tb/tb_dff.sv
// Directed bench: default dff, a 3-deep 8-bit pipeline, and a 3-deep pipeline with RST_VAL=0x3C.
`timescale 1ns/1ps
module tb_dff;

  logic       clk;
  logic       rst_a;
  logic [0:0] d_a;
  logic [0:0] q_a;
  logic       rst_b;
  logic [7:0] d_b;
  logic [7:0] q_p;
  logic [7:0] q_r;

  int checks = 0;
  int errors = 0;

  // Rising edges at 20, 40, 60 ns ...
  initial begin
    clk = 1'b1;
    forever #10 clk = ~clk;
  end

  dff u_def (
    .q   (q_a),
    .d   (d_a),
    .clk (clk),
    .rst (rst_a)
  );

  dff #(.WIDTH(8), .RST_VAL(8'h00), .DEPTH(3)) u_pipe (
    .q   (q_p),
    .d   (d_b),
    .clk (clk),
    .rst (rst_b)
  );

  dff #(.WIDTH(8), .RST_VAL(8'h3C), .DEPTH(3)) u_rval (
    .q   (q_r),
    .d   (d_b),
    .clk (clk),
    .rst (rst_b)
  );

  task automatic at(input int t);
    #(t - int'($time));
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s @%0t: observed=%h expected=%h", tag, $time, obs, exp);
      end
  endtask

  initial begin
    rst_a = 1'b0; d_a = 1'b0;
    rst_b = 1'b0; d_b = 8'hFF;

    at(15);  d_a = 1'b1;
    at(21);  chk("rst_hold_20", 8'(q_a), 8'h00);
             chk("pipe_rst_20", q_p, 8'h00);
             chk("rval_rst_20", q_r, 8'h3C);
    at(35);  d_a = 1'b0;
    at(41);  chk("rst_hold_40", 8'(q_a), 8'h00);
             chk("pipe_rst_40", q_p, 8'h00);
             chk("rval_rst_40", q_r, 8'h3C);
    at(45);  rst_b = 1'b1; d_b = 8'hA5;
    at(61);  chk("rst_hold_60", 8'(q_a), 8'h00);
             chk("pipe_lat1", q_p, 8'h00);
             chk("rval_lat1", q_r, 8'h3C);
    at(65);  d_a = 1'b1; d_b = 8'h00;
    at(81);  chk("rst_hold_80", 8'(q_a), 8'h00);
             chk("pipe_lat2", q_p, 8'h00);
             chk("rval_lat2", q_r, 8'h3C);
    at(90);  rst_a = 1'b1;
    at(101); chk("release_100", 8'(q_a), 8'h01);
             chk("pipe_lat3", q_p, 8'hA5);
             chk("rval_lat3", q_r, 8'hA5);
    at(121); chk("release_120", 8'(q_a), 8'h01);
             chk("pipe_after", q_p, 8'h00);
             chk("rval_after", q_r, 8'h00);
    at(125); d_b = 8'h5A;
    at(141); chk("release_140", 8'(q_a), 8'h01);
    at(145); d_b = 8'h11;
    at(161); chk("release_160", 8'(q_a), 8'h01);
    at(165); rst_b = 1'b0; d_b = 8'h77;
    at(181); chk("release_180", 8'(q_a), 8'h01);
             chk("pipe_flush", q_p, 8'h00);
             chk("rval_flush", q_r, 8'h3C);
    at(185); rst_b = 1'b1; d_b = 8'h22;
    at(201); chk("release_200", 8'(q_a), 8'h01);
             chk("pipe_nostale1", q_p, 8'h00);
             chk("rval_nostale1", q_r, 8'h3C);
    at(205); d_a = 1'b0;
    at(221); chk("d_low_220", 8'(q_a), 8'h00);
             chk("pipe_nostale2", q_p, 8'h00);
             chk("rval_nostale2", q_r, 8'h3C);
    at(225); d_a = 1'b1;
    at(230); d_a = 1'b0;
    at(241); chk("glitch_240", 8'(q_a), 8'h00);
             chk("pipe_post_rst", q_p, 8'h22);
             chk("rval_post_rst", q_r, 8'h22);
    at(245); d_a = 1'b1;
    at(261); chk("d_high_260", 8'(q_a), 8'h01);
             chk("pipe_hold_22", q_p, 8'h22);
    at(265); rst_a = 1'b0;
    at(270); rst_a = 1'b1;
    at(281); chk("rst_pulse_280", 8'(q_a), 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dff
